// File: rtl/resonator_pkg.sv
// resonator_pkg: FSM state encoding, default resonator constants and the saturating add used by pos/vel updates
package resonator_pkg;
  typedef enum logic [2:0] {IDLE, MUL, INTEG, DAMP, OUT} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMP_SHIFT = 9;
  localparam int DEF_SPRING_SHIFT = 6;
  localparam int DEF_DAMP_SHIFT = 6;
  localparam int DEF_QUIET = 16;
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
    logic signed [32:0] s, hi, lo;
    s = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    return s > hi ? 32'(hi) : s < lo ? 32'(lo) : 32'(s);
  endfunction
endpackage

// File: rtl/resonator_synth_if.sv
// resonator_synth_if: impact inputs (update_resonator, trigger_resonator, tension) and audio/status outputs (audio_sample, audio_pwm, busy, active, overrun)
interface resonator_synth_if;
  logic update_resonator;
  logic [2:0] trigger_resonator;
  logic [3:0] tension;
  logic [7:0] audio_sample;
  logic audio_pwm;
  logic busy;
  logic active;
  logic overrun;
  modport master(output update_resonator, trigger_resonator, tension, input audio_sample, audio_pwm, busy, active, overrun);
  modport slave(input update_resonator, trigger_resonator, tension, output audio_sample, audio_pwm, busy, active, overrun);
endinterface

// File: rtl/audio_pwm_dac.sv
// audio_pwm_dac: free-running 8-bit counter compared against audio_sample (in) to give registered audio_pwm (out); clk, rst sync active-high
module audio_pwm_dac (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] audio_sample,
  output logic       audio_pwm
);
  logic [7:0] pwm_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      audio_pwm <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      audio_pwm <= pwm_cnt < audio_sample;
    end
  end
endmodule

// File: rtl/resonator_synth.sv
// resonator_synth: damped mass-spring voice, one semi-implicit Euler step per update_resonator; clk, rst (sync active-high), bus (slave) carries impact inputs and audio/status outputs
module resonator_synth
  import resonator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMP_SHIFT = DEF_AMP_SHIFT,
  parameter int SPRING_SHIFT = DEF_SPRING_SHIFT,
  parameter int DAMP_SHIFT = DEF_DAMP_SHIFT,
  parameter int QUIET = DEF_QUIET
) (
  input logic clk,
  input logic rst,
  resonator_synth_if.slave bus
);
  localparam int AW = WIDTH + 4;
  localparam logic signed [WIDTH-1:0] q_lim = WIDTH'(QUIET);
  state_t state;
  logic signed [WIDTH-1:0] pos, vel, vel_d, pos_n;
  logic signed [AW-1:0] acc;
  logic [3:0] t_lat;
  logic [1:0] cnt;
  logic [2:0] pending_kick, kick;
  logic [7:0] sample;
  logic active_r, overrun_r, quiet, pwm;
  always_comb begin
    kick = bus.trigger_resonator != 3'd0 ? bus.trigger_resonator : pending_kick;
    vel_d = vel - (vel >>> DAMP_SHIFT);
    pos_n = WIDTH'(sat_add(32'(pos), 32'(vel_d), WIDTH));
    quiet = vel_d > -q_lim && vel_d < q_lim && pos_n > -q_lim && pos_n < q_lim;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pos <= '0;
      vel <= '0;
      acc <= '0;
      t_lat <= '0;
      cnt <= '0;
      pending_kick <= '0;
      sample <= 8'd128;
      active_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      pending_kick <= (state == IDLE && bus.update_resonator) ? 3'd0 : bus.trigger_resonator != 3'd0 ? bus.trigger_resonator : pending_kick;
      if (state != IDLE && bus.update_resonator) overrun_r <= 1'b1;
      case (state)
        IDLE: if (bus.update_resonator) begin
          t_lat <= bus.tension;
          acc <= '0;
          cnt <= '0;
          if (kick != 3'd0) vel <= WIDTH'(kick) << AMP_SHIFT;
          state <= MUL;
        end
        MUL: begin
          if (t_lat[cnt]) acc <= acc + (AW'(pos) <<< cnt);
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= INTEG;
        end
        INTEG: begin
          vel <= WIDTH'(sat_add(32'(vel), -(32'(acc >>> SPRING_SHIFT)), WIDTH));
          state <= DAMP;
        end
        DAMP: begin
          vel <= quiet ? '0 : vel_d;
          pos <= quiet ? '0 : pos_n;
          active_r <= !quiet;
          state <= OUT;
        end
        OUT: begin
          sample <= {~pos[WIDTH-1], pos[WIDTH-2 -: 7]};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  audio_pwm_dac u_dac (.clk(clk), .rst(rst), .audio_sample(sample), .audio_pwm(pwm));
  assign bus.audio_sample = sample;
  assign bus.audio_pwm = pwm;
  assign bus.busy = state != IDLE;
  assign bus.active = active_r;
  assign bus.overrun = overrun_r;
endmodule

// File: tb/tb_resonator_synth.sv
// tb_resonator_synth: directed and randomized checks of resonator_synth against a step-level arithmetic model
module tb_resonator_synth;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  resonator_synth_if bus();
  resonator_synth dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  int m_pos, m_vel, m_pend, m_sample, m_active, m_ovr, m_left;
  bit m_done;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int sat16(input longint x);
    return x > 32767 ? 32767 : x < -32768 ? -32768 : int'(x);
  endfunction
  function automatic void model_edge(input bit upd, input int trig, input int ten);
    int kick, acc, vd, np;
    m_done = 1'b0;
    if (m_left == 0 && upd) begin
      kick = trig != 0 ? trig : m_pend;
      m_pend = 0;
      if (kick != 0) m_vel = kick * 512;
      acc = m_pos * ten;
      m_vel = sat16(longint'(m_vel) - (acc >>> 6));
      vd = m_vel - (m_vel >>> 6);
      np = sat16(longint'(m_pos) + vd);
      if (vd > -16 && vd < 16 && np > -16 && np < 16) begin
        vd = 0;
        np = 0;
      end
      m_vel = vd;
      m_pos = np;
      m_active = (np != 0 || vd != 0) ? 1 : 0;
      m_sample = (np >>> 8) + 128;
      m_left = 7;
    end else begin
      if (upd) m_ovr = 1;
      if (trig != 0) m_pend = trig;
      if (m_left > 0) begin
        m_left--;
        m_done = m_left == 0;
      end
    end
  endfunction
  task automatic drive(input bit upd, input int trig, input int ten);
    bus.update_resonator = upd;
    bus.trigger_resonator = 3'(trig);
    bus.tension = 4'(ten);
    @(posedge clk);
    model_edge(upd, trig, ten);
    #1;
    check("busy", bus.busy, m_left != 0);
    if (m_done) begin
      check("pos", dut.pos, m_pos);
      check("vel", dut.vel, m_vel);
      check("active", bus.active, m_active);
      check("sample", bus.audio_sample, m_sample);
      check("overrun", bus.overrun, m_ovr);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.update_resonator = 1'b0;
    bus.trigger_resonator = 3'd0;
    bus.tension = 4'd0;
    @(posedge clk);
    m_pos = 0; m_vel = 0; m_pend = 0; m_sample = 128; m_active = 0; m_ovr = 0; m_left = 0;
    #1;
    rst = 1'b0;
    check("rst_pos", dut.pos, 0);
    check("rst_vel", dut.vel, 0);
    check("rst_sample", bus.audio_sample, 128);
    check("rst_busy", bus.busy, 0);
    check("rst_active", bus.active, 0);
    check("rst_overrun", bus.overrun, 0);
  endtask
  task automatic step(input int trig, input int ten, input int ovr_at, input bit rnd);
    drive(1'b1, trig, ten);
    for (int i = 1; i <= 7; i++)
      drive(i == ovr_at, (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0, rnd ? int'($urandom_range(0, 15)) : ten);
  endtask
  task automatic pwm_check(input string tag);
    int n = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 0, 0);
      n += int'(bus.audio_pwm);
    end
    check(tag, n, m_sample);
  endtask
  initial begin
    bus.update_resonator = 1'b0;
    bus.trigger_resonator = 3'd0;
    bus.tension = 4'd0;
    do_reset();
    check("rst_pwm", bus.audio_pwm, 0);
    for (int i = 0; i < 3; i++) step(0, int'($urandom_range(0, 15)), 0, 1'b0);
    check("silent_sample", bus.audio_sample, 128);
    check("silent_active", bus.active, 0);
    pwm_check("pwm_128");
    drive(1'b0, 7, 4);
    step(0, 4, 0, 1'b0);
    check("kick_vel", dut.vel, 3528);
    check("kick_pos", dut.pos, 3528);
    check("kick_sample", bus.audio_sample, 141);
    step(0, 4, 0, 1'b0);
    check("step2_vel", dut.vel, 3257);
    check("step2_pos", dut.pos, 6785);
    check("step2_sample", bus.audio_sample, 154);
    do_reset();
    step(7, 15, 0, 1'b0);
    for (int i = 0; i < 1000 && m_active != 0; i++) step(0, 15, 0, 1'b0);
    check("quench_active", bus.active, m_active);
    check("quench_sample", bus.audio_sample, m_sample);
    do_reset();
    for (int i = 0; i < 12; i++) step(7, 0, 0, 1'b0);
    check("sat_pos", dut.pos, 32767);
    check("sat_sample", bus.audio_sample, 255);
    pwm_check("pwm_255");
    step(0, 4, 3, 1'b0);
    check("ovr_flag", bus.overrun, 1);
    do_reset();
    drive(1'b1, 5, 9);
    drive(1'b0, 3, 9);
    drive(1'b0, 0, 9);
    drive(1'b0, 0, 9);
    do_reset();
    step(0, 9, 0, 1'b0);
    check("post_rst_sample", bus.audio_sample, 128);
    check("post_rst_active", bus.active, 0);
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 3)) drive(1'b0, $urandom_range(0, 1) != 0 ? int'($urandom_range(1, 7)) : 0, 0);
      step($urandom_range(0, 1) != 0 ? int'($urandom_range(0, 7)) : 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 2 ? int'($urandom_range(1, 7)) : 0, 1'b1);
    end
    pwm_check("pwm_rand");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/resonator_synth.md
Name: resonator_synth

Overview:
- Audio voice driven by the frame orchestrator's impact outputs (trigger_resonator, tension, update_resonator).
- Models a damped mass-spring resonator in fixed point: position and velocity, semi-implicit Euler integration.
- Produces an 8-bit offset-binary sample plus a 1-bit PWM audio pin.
- One integration step per update_resonator pulse; the spring multiply is done serially over several cycles.

Parameters:
WIDTH, 16, signed width of pos/vel state
AMP_SHIFT, 9, kick velocity = impact << AMP_SHIFT
SPRING_SHIFT, 6, spring force = (pos*tension) >>> SPRING_SHIFT
DAMP_SHIFT, 6, per-step damping = vel >>> DAMP_SHIFT
QUIET, 16, quench threshold on |pos| and |vel|

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
update_resonator  in  1  one-cycle step request
trigger_resonator  in  3  impact strength; 0 = none, sampled every cycle
tension  in  4  spring constant, unsigned, latched at step start
audio_sample  out  8  offset-binary sample, 128 = silence
audio_pwm  out  1  PWM of audio_sample
busy  out  1  step in progress (state != IDLE)
active  out  1  pos != 0 or vel != 0
overrun  out  1  sticky: update_resonator arrived while busy

Behaviour:
- Reset values:
  - pos = 0, vel = 0, pending_kick = 0, state = IDLE.
  - audio_sample = 128, audio_pwm = 0, pwm_cnt = 0.
  - busy = 0, active = 0, overrun = 0.
  - rst asserted mid-step aborts the step, clears all of the above and drops any pending kick.
- Kick capture:
  - Any cycle with trigger_resonator != 0 loads pending_kick.
  - Latest nonzero value wins; zero never overwrites.
- FSM states: IDLE, MUL, INTEG, DAMP, OUT.
- IDLE, edge k with update_resonator = 1:
  - t_lat <= tension; acc <= 0; cnt <= 0.
  - If pending_kick != 0: vel <= pending_kick << AMP_SHIFT (replaces vel, positive sign).
  - pending_kick <= 0, unless trigger_resonator != 0 in this same cycle, in which case that value applies to this step.
  - Go to MUL.
- MUL, edges k+1..k+4: if t_lat[cnt] then acc += pos <<< cnt. acc is WIDTH+4 bits signed, no overflow possible. cnt++. After cnt = 3, go to INTEG.
- INTEG, edge k+5: vel <= sat(vel - (acc >>> SPRING_SHIFT)).
- DAMP, edge k+6:
  - vel_d = vel - (vel >>> DAMP_SHIFT); vel <= vel_d; pos <= sat(pos + vel_d).
  - Quench: if |vel_d| < QUIET and |new pos| < QUIET, force both to 0.
- OUT, edge k+7: audio_sample <= {~pos[WIDTH-1], pos[WIDTH-2:WIDTH-8]}; go to IDLE.
- Arithmetic:
  - sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - All shifts are arithmetic.
- Timing: busy = 1 on edges k+1..k+7 outputs; first free cycle is k+8.
- update_resonator while busy: ignored, sets overrun (cleared only by rst).
- tension = 0: no spring force, damping only.
- active is registered and recomputed each DAMP from the post-quench values.
- PWM:
  - 8-bit free-running pwm_cnt increments every clock and wraps 255 -> 0.
  - audio_pwm <= (pwm_cnt < audio_sample), registered.
  - audio_sample = 0 gives a constant 0 output.

Decomposition:
- resonator_pkg holds:
  - state enum (IDLE, MUL, INTEG, DAMP, OUT);
  - default WIDTH/shift constants;
  - the sat_add function (signed add with clamp).
- One sub-module, audio_pwm_dac: pwm_cnt plus comparator, inputs clk, rst, audio_sample; output audio_pwm.

Test Plan:
- Reset, no stimulus, 3 update pulses: audio_sample stays 128, active = 0, vel = pos = 0, busy pulses 7 cycles each.
- trigger = 7, tension = 4, then update:
  - vel 3584 -> 3528, pos = 3528, audio_sample = 141 at k+7.
  - Next step: vel = 3257, pos = 6785, audio_sample = 154.
- Kick then 300 steps with tension = 15: pos sign alternates, amplitude decays, quench reached, active -> 0, audio_sample = 128.
- tension = 0, trigger = 7 before each of 12 steps: pos saturates at 32767, audio_sample = 255, no wrap.
- update_resonator at k+3 of a running step: ignored, overrun = 1; step completes at k+7 unchanged.
- rst at k+4 of a kicked step: next cycle pos = vel = 0, audio_sample = 128, busy = 0; following update with no trigger keeps silence.
